// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two SRAM-like masters (inst, data) sharing one SRAM-like port, one transaction outstanding.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module sram_like_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t state;
  logic own, win, sel, sel_req, resp_ok;
`ifdef SRAM_ARB_RR_EN
  logic rr_last;
  always_comb win = (inst_req & data_req) ? ~rr_last : data_req;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rr_last <= 1'b0;
    else if (mem_req & mem_addr_ok) rr_last <= sel;
`else
  always_comb win = data_req;
`endif
  // Request fields are zeroed whenever nothing is being presented downstream.
  always_comb begin
    sel = (state == ADDR) ? own : win;
    sel_req = sel ? data_req : inst_req;
    mem_req = (state != RESP) & sel_req;
    mem_wr = mem_req & (sel ? data_wr : inst_wr);
    mem_size = mem_req ? (sel ? data_size : inst_size) : 2'b0;
    mem_addr = mem_req ? (sel ? data_addr : inst_addr) : 32'h0;
    mem_wdata = mem_req ? (sel ? data_wdata : inst_wdata) : 32'h0;
    inst_addr_ok = mem_req & ~sel & mem_addr_ok;
    data_addr_ok = mem_req & sel & mem_addr_ok;
    resp_ok = (state == RESP) & mem_data_ok;
    inst_data_ok = resp_ok & ~own;
    data_data_ok = resp_ok & own;
    inst_rdata = inst_data_ok ? mem_rdata : 32'h0;
    data_rdata = data_data_ok ? mem_rdata : 32'h0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      own <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_req) begin
          own <= win;
          state <= mem_addr_ok ? RESP : ADDR;
        end
        ADDR: state <= !mem_req ? IDLE : mem_addr_ok ? RESP : ADDR;
        RESP: state <= mem_data_ok ? IDLE : RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed test-plan steps plus random traffic checked against a transaction-level model.
module tb_sram_like_arbiter;
`ifdef SRAM_ARB_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0] inst_size = 0, data_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr;
  logic [1:0] mem_size;
  logic [31:0] mem_rdata = 0;
  logic mem_addr_ok = 0, mem_data_ok = 0;
  int n_chk = 0, n_fail = 0;
  int locked = -1, outst = -1, last = 0, g = 0;
  logic go;
  sram_like_arbiter dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // Model: at most one locked grant and one outstanding transaction, tracked by requester index.
  task automatic eval();
    logic rq[2], wr[2];
    logic [1:0] sz[2];
    logic [31:0] ad[2], wd[2];
    logic [33:0] eu[2];
    logic [67:0] em;
    @(negedge clk);
    if (!rstn) begin locked = -1; outst = -1; last = 0; end
    rq = '{inst_req, data_req};
    wr = '{inst_wr, data_wr};
    sz = '{inst_size, data_size};
    ad = '{inst_addr, data_addr};
    wd = '{inst_wdata, data_wdata};
    g = locked >= 0 ? locked : (rq[0] && rq[1]) ? (RR != 0 ? 1 - last : 1) : (rq[1] ? 1 : 0);
    go = outst < 0 && rq[g];
    em = go ? {1'b1, wr[g], sz[g], ad[g], wd[g]} : 68'h0;
    for (int k = 0; k < 2; k++)
      eu[k] = {go && g == k && mem_addr_ok, outst == k && mem_data_ok,
               (outst == k && mem_data_ok) ? mem_rdata : 32'h0};
    chk("mem", {mem_req, mem_wr, mem_size, mem_addr, mem_wdata}, em);
    chk("inst", {34'h0, inst_addr_ok, inst_data_ok, inst_rdata}, {34'h0, eu[0]});
    chk("data", {34'h0, data_addr_ok, data_data_ok, data_rdata}, {34'h0, eu[1]});
  endtask
  task automatic tick();
    @(posedge clk);
    if (rstn) begin
      if (outst >= 0) begin
        if (mem_data_ok) outst = -1;
      end else if (go) begin
        if (mem_addr_ok) begin outst = g; locked = -1; last = g; end
        else locked = g;
      end else locked = -1;
    end
    #1;
  endtask
  task automatic cyc();
    eval();
    tick();
  endtask
  task automatic set_inst(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    inst_req = r; inst_wr = w; inst_size = s; inst_addr = a; inst_wdata = d;
  endtask
  task automatic set_data(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    data_req = r; data_wr = w; data_size = s; data_addr = a; data_wdata = d;
  endtask
  task automatic set_mem(input logic a, input logic d, input logic [31:0] rd);
    mem_addr_ok = a; mem_data_ok = d; mem_rdata = rd;
  endtask
  initial begin
    eval();
    chk("reset_mem_req", {67'h0, mem_req}, 68'h0);
    chk("reset_ok", {64'h0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 68'h0);
    tick();
    rstn = 1'b1;
    cyc();
    // single inst read
    set_inst(1, 0, 2, 32'h1000, 0); set_mem(1, 0, 0);
    eval();
    chk("t1_aok", {67'h0, inst_addr_ok}, 68'h1);
    chk("t1_addr", {36'h0, mem_addr}, 68'h1000);
    tick();
    set_inst(0, 0, 0, 0, 0); set_mem(0, 0, 0);
    cyc(); cyc();
    set_mem(0, 1, 32'hDEAD_BEEF);
    eval();
    chk("t1_dok", {35'h0, inst_data_ok, inst_rdata}, {35'h0, 1'b1, 32'hDEAD_BEEF});
    chk("t1_data_quiet", {35'h0, data_data_ok, data_rdata}, 68'h0);
    tick();
    // contention
    set_inst(1, 0, 2, 32'h100, 0); set_data(1, 0, 2, 32'h200, 0); set_mem(1, 0, 0);
    eval();
    chk("t2_first", {36'h0, mem_addr}, 68'h200);
    tick();
    set_data(0, 0, 0, 0, 0); set_mem(0, 0, 0);
    eval();
    chk("t2_resp_idle", {66'h0, mem_req, inst_addr_ok}, 68'h0);
    tick();
    set_mem(0, 1, 32'h55);
    cyc();
    set_data(1, 0, 2, 32'h204, 0); set_mem(1, 0, 0);
    eval();
    chk("t2_round2", {36'h0, mem_addr}, {36'h0, RR != 0 ? 32'h100 : 32'h204});
    tick();
    set_inst(0, 0, 0, 0, 0); set_data(0, 0, 0, 0, 0); set_mem(0, 1, 32'h66);
    cyc();
    set_mem(0, 0, 0);
    cyc();
    // delayed mem_addr_ok on a data write
    set_data(1, 1, 2, 32'h3000, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_inst(1, 0, 2, 32'h4000, 0);
      eval();
      chk("t3_hold", {mem_req, mem_wr, mem_size, mem_addr, mem_wdata}, {2'b11, 2'd2, 32'h3000, 32'h1234_5678});
      chk("t3_inst_aok", {67'h0, inst_addr_ok}, 68'h0);
      tick();
    end
    set_mem(1, 0, 0);
    eval();
    chk("t3_aok", {67'h0, data_addr_ok}, 68'h1);
    tick();
    set_data(0, 0, 0, 0, 0); set_mem(0, 1, 32'h77);
    cyc();
    set_mem(1, 0, 0);
    eval();
    chk("t3_inst_next", {67'h0, inst_addr_ok}, 68'h1);
    tick();
    set_inst(0, 0, 0, 0, 0); set_mem(0, 1, 32'h88);
    cyc();
    // owner abandons in ADDR
    set_mem(0, 0, 0); set_data(1, 0, 1, 32'h5000, 0); set_inst(1, 0, 2, 32'h6000, 0);
    cyc();
    set_data(0, 0, 0, 0, 0);
    eval();
    chk("t4_drop", {66'h0, data_data_ok, mem_req}, 68'h0);
    tick();
    set_mem(1, 0, 0);
    eval();
    chk("t4_inst", {35'h0, inst_addr_ok, mem_addr}, {35'h0, 1'b1, 32'h6000});
    tick();
    set_inst(0, 0, 0, 0, 0); set_mem(0, 1, 32'h99);
    cyc();
    // reset in RESP then late data_ok
    set_inst(1, 0, 2, 32'h7000, 0); set_mem(1, 0, 0);
    cyc();
    set_inst(0, 0, 0, 0, 0); set_mem(0, 0, 0);
    rstn = 1'b0;
    eval();
    chk("t5_reset", {mem_req, mem_wr, mem_size, mem_addr, mem_wdata}, 68'h0);
    tick();
    rstn = 1'b1; set_mem(0, 1, 32'hAAAA_AAAA);
    eval();
    chk("t5_late", {34'h0, inst_data_ok, data_data_ok, inst_rdata}, 68'h0);
    tick();
    // spurious handshakes in IDLE
    set_mem(1, 1, 32'h1111);
    eval();
    chk("t6_spurious", {64'h0, inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 68'h0);
    tick();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rstn = $urandom_range(0, 299) != 0;
      if (!inst_req) set_inst($urandom_range(0, 2) == 0, 1'($urandom), 2'($urandom), $urandom, $urandom);
      else if (inst_addr_ok || $urandom_range(0, 15) == 0) inst_req = 1'b0;
      if (!data_req) set_data($urandom_range(0, 2) == 0, 1'($urandom), 2'($urandom), $urandom, $urandom);
      else if (data_addr_ok || $urandom_range(0, 15) == 0) data_req = 1'b0;
      set_mem($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
